// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg
//   Shared definitions for the ID-stage immediate generator: RISC-V major
//   opcodes (instr[6:2]) and the 3-bit immediate format class codes.
//   No ports; imported by imm_decode_comb and imm_gen_pipe.
package imm_gen_pipe_pkg;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_IMM_32   = 5'b00110;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_32       = 5'b01110;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_SH   = 3'd7
  } imm_type_e;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb
//   Purely combinational immediate decoder for one 32-bit instruction word.
//   Ports:
//     instr    in   32     raw instruction word
//     imm      out  XLEN   sign/zero-extended immediate (0 when no immediate)
//     imm_type out  3      format class (IMM_NONE..IMM_SH)
//     illegal  out  1      bad low bits, unknown opcode, or RV64-only op at XLEN=32
module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  logic [4:0]      opc;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh, imm_sh_w;

  assign opc      = instr[6:2];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Signed casts widen with instr[31] as the sign bit.
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_z = XLEN'(instr[19:15]);

  // RV64 shifts use a 6-bit shamt; the *W forms and RV32 use 5 bits.
  assign imm_sh   = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign imm_sh_w = XLEN'(instr[24:20]);

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OP_LOAD, OP_JALR: begin
          imm      = imm_i;
          imm_type = IMM_I;
        end
        OP_IMM: begin
          imm      = is_shift ? imm_sh : imm_i;
          imm_type = is_shift ? IMM_SH : IMM_I;
        end
        OP_IMM_32: begin
          imm      = is_shift ? imm_sh_w : imm_i;
          imm_type = is_shift ? IMM_SH : IMM_I;
          illegal  = (XLEN == 32);
        end
        OP_STORE: begin
          imm      = imm_s;
          imm_type = IMM_S;
        end
        OP_BRANCH: begin
          imm      = imm_b;
          imm_type = IMM_B;
        end
        OP_LUI, OP_AUIPC: begin
          imm      = imm_u;
          imm_type = IMM_U;
        end
        OP_JAL: begin
          imm      = imm_j;
          imm_type = IMM_J;
        end
        OP_SYSTEM: begin
          imm      = funct3[2] ? imm_z : imm_i;
          imm_type = funct3[2] ? IMM_Z : IMM_I;
        end
        OP_OP, OP_MISC_MEM: ;
        OP_32: illegal = (XLEN == 32);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered immediate generator with a 2-entry skid FIFO. Each accepted
//   instruction is decoded on entry and its result appears at out_* one cycle
//   later; the tag rides along untouched.
//   Ports:
//     clk, rst (sync, active-low), flush
//     in_valid/in_ready/in_instr/in_tag          upstream handshake
//     out_valid/out_ready                         downstream handshake
//     out_imm/out_type/out_illegal/out_tag        head-entry result
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_type_e        dec_type;
  logic             dec_illegal;

  // Entry 0 is always the head; entry 1 is only valid when entry 0 is.
  logic [1:0]       v_q, v_d;
  logic [XLEN-1:0]  imm0, imm1;
  logic [2:0]       typ0, typ1;
  logic             ill0, ill1;
  logic [TAG_W-1:0] tag0, tag1;

  logic push, pop, ld0_new, ld0_e1, ld1_new;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  assign push = in_valid && in_ready;
  assign pop  = v_q[0] && out_ready;

  always_comb begin
    v_d     = v_q;
    ld0_new = 1'b0;
    ld0_e1  = 1'b0;
    ld1_new = 1'b0;
    if (flush) begin
      v_d = 2'b00;
    end else if (pop) begin
      // A push here can only happen with entry 1 empty, since full drops in_ready.
      if (v_q[1]) begin
        ld0_e1 = 1'b1;
        v_d[1] = 1'b0;
      end else if (push) begin
        ld0_new = 1'b1;
      end else begin
        v_d[0] = 1'b0;
      end
    end else if (push) begin
      if (!v_q[0]) begin
        ld0_new = 1'b1;
        v_d[0]  = 1'b1;
      end else begin
        ld1_new = 1'b1;
        v_d[1]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q      <= 2'b00;
      in_ready <= 1'b0;
      imm0     <= '0;
      typ0     <= IMM_NONE;
      ill0     <= 1'b0;
      tag0     <= '0;
      imm1     <= '0;
      typ1     <= IMM_NONE;
      ill1     <= 1'b0;
      tag1     <= '0;
    end else begin
      v_q      <= v_d;
      in_ready <= !(v_d[0] && v_d[1]);
      if (ld0_new) begin
        imm0 <= dec_imm;
        typ0 <= dec_type;
        ill0 <= dec_illegal;
        tag0 <= in_tag;
      end else if (ld0_e1) begin
        imm0 <= imm1;
        typ0 <= typ1;
        ill0 <= ill1;
        tag0 <= tag1;
      end
      if (ld1_new) begin
        imm1 <= dec_imm;
        typ1 <= dec_type;
        ill1 <= dec_illegal;
        tag1 <= in_tag;
      end
    end
  end

  assign out_valid   = v_q[0];
  assign out_imm     = imm0;
  assign out_type    = typ0;
  assign out_illegal = ill0;
  assign out_tag     = tag0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Directed bench: one XLEN=64 and one XLEN=32 instance driven in lockstep,
//   hand-computed expected immediates, back-pressure, flush and mid-stream reset.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        r64_in_ready, r64_valid, r64_ill;
  logic [63:0] r64_imm;
  logic [2:0]  r64_type;
  logic [31:0] r64_tag;
  logic        r32_in_ready, r32_valid, r32_ill;
  logic [31:0] r32_imm;
  logic [2:0]  r32_type;
  logic [31:0] r32_tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r64_valid), .out_ready(out_ready), .out_imm(r64_imm),
    .out_type(r64_type), .out_illegal(r64_ill), .out_tag(r64_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r32_valid), .out_ready(out_ready), .out_imm(r32_imm),
    .out_type(r32_type), .out_illegal(r32_ill), .out_tag(r32_tag)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_v64"}, 64'(r64_valid), 64'd0);
    chk({nm, "_imm64"}, r64_imm, 64'd0);
    chk({nm, "_typ64"}, 64'(r64_type), 64'd0);
    chk({nm, "_ill64"}, 64'(r64_ill), 64'd0);
    chk({nm, "_tag64"}, 64'(r64_tag), 64'd0);
    chk({nm, "_rdy64"}, 64'(r64_in_ready), 64'd0);
    chk({nm, "_v32"}, 64'(r32_valid), 64'd0);
    chk({nm, "_imm32"}, 64'(r32_imm), 64'd0);
    chk({nm, "_rdy32"}, 64'(r32_in_ready), 64'd0);
  endtask

  // Push one instruction (out_ready=1) and check the result one edge later.
  task automatic send_check(input string nm, input logic [31:0] ins, input logic [31:0] tg,
                            input logic [63:0] e64, input logic [31:0] e32,
                            input logic [2:0] t64, input logic [2:0] t32,
                            input logic il64, input logic il32);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_tag = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_v64"}, 64'(r64_valid), 64'd1);
    chk({nm, "_imm64"}, r64_imm, e64);
    chk({nm, "_typ64"}, 64'(r64_type), 64'(t64));
    chk({nm, "_ill64"}, 64'(r64_ill), 64'(il64));
    chk({nm, "_tag64"}, 64'(r64_tag), 64'(tg));
    chk({nm, "_v32"}, 64'(r32_valid), 64'd1);
    chk({nm, "_imm32"}, 64'(r32_imm), 64'(e32));
    chk({nm, "_typ32"}, 64'(r32_type), 64'(t32));
    chk({nm, "_ill32"}, 64'(r32_ill), 64'(il32));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_tag = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");

    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst64", 64'(r64_in_ready), 64'd1);
    chk("rdy_after_rst32", 64'(r32_in_ready), 64'd1);
    chk("empty_after_rst", 64'(r64_valid), 64'd0);

    // types: NONE=0 I=1 S=2 B=3 U=4 J=5 Z=6 SH=7
    send_check("addi",   32'hFFF00093, 32'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 3'd1, 1'b0, 1'b0);
    send_check("sw",     32'hFE112E23, 32'h1004, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd2, 3'd2, 1'b0, 1'b0);
    send_check("beq",    32'hFE000CE3, 32'h1008, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd3, 3'd3, 1'b0, 1'b0);
    send_check("lui",    32'h800000B7, 32'h100C, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 3'd4, 1'b0, 1'b0);
    send_check("slli",   32'h03F09093, 32'h1010, 64'd63, 32'd31, 3'd7, 3'd7, 1'b0, 1'b0);
    send_check("csrrwi", 32'h0FFFD073, 32'h1014, 64'd31, 32'd31, 3'd6, 3'd6, 1'b0, 1'b0);
    send_check("jal",    32'hFFDFF0EF, 32'h1018, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd5, 3'd5, 1'b0, 1'b0);
    send_check("add",    32'h002081B3, 32'h101C, 64'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    send_check("addw",   32'h002081BB, 32'h1020, 64'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    send_check("slliw",  32'h01F0909B, 32'h1024, 64'd31, 32'd31, 3'd7, 3'd7, 1'b0, 1'b1);
    send_check("lowbits",32'h00000010, 32'h1028, 64'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    send_check("badopc", 32'h0000007F, 32'h102C, 64'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    send_check("ecall",  32'h00000073, 32'h1030, 64'd0, 32'd0, 3'd1, 3'd1, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("drain_empty", 64'(r64_valid), 64'd0);

    // Back-pressure: three tags stream in with out_ready low.
    @(negedge clk); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hA;
    @(posedge clk); #1;
    chk("bp_rdy1", 64'(r64_in_ready), 64'd1);
    @(negedge clk); in_instr = 32'hFE112E23; in_tag = 32'hB;
    @(posedge clk); #1;
    chk("bp_full_rdy64", 64'(r64_in_ready), 64'd0);
    chk("bp_full_rdy32", 64'(r32_in_ready), 64'd0);
    @(negedge clk); in_instr = 32'h800000B7; in_tag = 32'hC;
    @(posedge clk); #1;
    chk("bp_hold_tag", 64'(r64_tag), 64'hA);
    chk("bp_hold_imm", r64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("bp_hold_rdy", 64'(r64_in_ready), 64'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_tagB", 64'(r64_tag), 64'hB);
    chk("bp_immB", r64_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("bp_rdy_again", 64'(r64_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_tagC", 64'(r64_tag), 64'hC);
    chk("bp_immC", r64_imm, 64'hFFFF_FFFF_8000_0000);
    chk("bp_tagC32", 64'(r32_tag), 64'hC);
    chk("bp_vC", 64'(r64_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_drained", 64'(r64_valid), 64'd0);

    // Flush with two entries held, plus a same-cycle push that must be dropped.
    @(negedge clk); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h11;
    @(posedge clk);
    @(negedge clk); in_tag = 32'h12;
    @(posedge clk); #1;
    chk("fl_pre_v", 64'(r64_valid), 64'd1);
    @(negedge clk); flush = 1'b1; in_tag = 32'h13;
    @(posedge clk); #1;
    chk("fl_v64", 64'(r64_valid), 64'd0);
    chk("fl_v32", 64'(r32_valid), 64'd0);
    chk("fl_rdy", 64'(r64_in_ready), 64'd1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl_dropped", 64'(r64_valid), 64'd0);

    // Reset mid-stream.
    @(negedge clk); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h800000B7; in_tag = 32'h21;
    @(posedge clk); #1;
    chk("mr_pre_v", 64'(r64_valid), 64'd1);
    @(negedge clk); rst = 1'b0; in_tag = 32'h22;
    @(posedge clk); #1;
    chk_reset("midrst");
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mr_rdy", 64'(r64_in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
